// File: rtl/cmplt_collector_pkg.sv
// Sizing and count helpers shared between the completion collector and the ROB.
package cmplt_collector_pkg;

  localparam int DEF_ELEMENTS   = 15;
  localparam int DEF_PUSH_WIDTH = 3;
  localparam int DEF_NUM_UNITS  = 4;

  function automatic int tag_width(input int elements);
    return $clog2(elements) + 1;
  endfunction

  function automatic int ct_width(input int push_width);
    return $clog2(push_width) + 1;
  endfunction

  function automatic int cnt_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cmplt_collector_skid.sv
// Two-entry skid FIFO between one execution unit and the completion packer.
module cmplt_skid
  import cmplt_collector_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_tag,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] head,
  output logic         nonempty,
  input  logic         pop
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         ready_q, ready_d;
  logic         push, do_pop;

  // Ready is a flop of next occupancy, so a full FIFO stays not-ready in its pop cycle.
  always_comb begin
    push     = in_valid & ready_q;
    do_pop   = pop & (cnt_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_tag;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, do_pop};
    ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready = ready_q;
  assign head     = mem_q[rd_ptr_q];
  assign nonempty = (cnt_q != 2'd0);

endmodule

// File: rtl/cmplt_collector.sv
// Collects completed ROB tags from the execution units and packs them,
// round-robin, onto the ROB's count-handshake completion port.
module cmplt_collector
  import cmplt_collector_pkg::*;
#(
  parameter  int ELEMENTS   = DEF_ELEMENTS,
  parameter  int PUSH_WIDTH = DEF_PUSH_WIDTH,
  parameter  int NUM_UNITS  = DEF_NUM_UNITS,
  localparam int TAG_WIDTH  = tag_width(ELEMENTS),
  localparam int CT_WIDTH   = ct_width(PUSH_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_UNITS*TAG_WIDTH-1:0]  fu_tag,
  input  logic [NUM_UNITS-1:0]            fu_valid,
  output logic [NUM_UNITS-1:0]            fu_ready,
  output logic [PUSH_WIDTH*TAG_WIDTH-1:0] completed,
  output logic [CT_WIDTH-1:0]             cmplt_valid_ct,
  input  logic [CT_WIDTH-1:0]             cmplt_ready_ct
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [TAG_WIDTH-1:0] head [NUM_UNITS];
  logic [NUM_UNITS-1:0] nonempty, pop;
  logic [UW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [UW-1:0]        slot_unit [PUSH_WIDTH];
  logic [UW-1:0]        scan_u;
  logic [CT_WIDTH-1:0]  filled, num_taken;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    cmplt_skid #(.W(TAG_WIDTH)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_tag   (fu_tag[u*TAG_WIDTH +: TAG_WIDTH]),
      .in_valid (fu_valid[u]),
      .in_ready (fu_ready[u]),
      .head     (head[u]),
      .nonempty (nonempty[u]),
      .pop      (pop[u])
    );
  end

  always_comb begin
    filled    = '0;
    scan_u    = '0;
    completed = '0;
    for (int s = 0; s < PUSH_WIDTH; s++) slot_unit[s] = '0;

    // Rotating scan from rr_ptr; each unit contributes at most its head tag.
    for (int k = 0; k < NUM_UNITS; k++) begin
      scan_u = UW'((int'(rr_ptr_q) + k) % NUM_UNITS);
      if (nonempty[scan_u] && (filled < CT_WIDTH'(PUSH_WIDTH))) begin
        for (int s = 0; s < PUSH_WIDTH; s++) begin
          if (CT_WIDTH'(s) == filled) begin
            completed[s*TAG_WIDTH +: TAG_WIDTH] = head[scan_u];
            slot_unit[s]                        = scan_u;
          end
        end
        filled = filled + CT_WIDTH'(1);
      end
    end

    num_taken = CT_WIDTH'(cnt_min(int'(filled),
                                  cnt_min(int'(cmplt_ready_ct), PUSH_WIDTH)));

    // Untaken slots are simply not popped and get re-arbitrated next cycle.
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int s = 0; s < PUSH_WIDTH; s++) begin
      if (CT_WIDTH'(s) < num_taken) pop[slot_unit[s]] = 1'b1;
      if (CT_WIDTH'(s + 1) == num_taken)
        rr_ptr_d = UW'((int'(slot_unit[s]) + 1) % NUM_UNITS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign cmplt_valid_ct = filled;

endmodule

// File: tb/tb_cmplt_collector.sv
// Self-checking bench for cmplt_collector: queue-based model of the per-unit
// FIFOs and the round-robin pointer, checked against the DUT every cycle.
module tb_cmplt_collector;

  localparam int TW = 5;
  localparam int PW = 3;
  localparam int NU = 4;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NU*TW-1:0]  fu_tag = '0;
  logic [NU-1:0]     fu_valid = '0;
  logic [NU-1:0]     fu_ready;
  logic [PW*TW-1:0]  completed;
  logic [CW-1:0]     cmplt_valid_ct;
  logic [CW-1:0]     cmplt_ready_ct = '0;

  int total = 0;
  int bad   = 0;

  logic [TW-1:0] mq [NU][$];
  int  m_rr = 0;
  bit  m_warm = 1'b0;
  int  n_deliv [NU];
  int  miss [NU];
  int  max_miss = 0;
  bit  fair_on = 1'b0;

  always #5 clk = ~clk;

  cmplt_collector dut (
    .clk            (clk),
    .rst            (rst),
    .fu_tag         (fu_tag),
    .fu_valid       (fu_valid),
    .fu_ready       (fu_ready),
    .completed      (completed),
    .cmplt_valid_ct (cmplt_valid_ct),
    .cmplt_ready_ct (cmplt_ready_ct)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Called on a falling edge: drive, compare DUT against model, advance model, wait one cycle.
  task automatic step(input logic [NU-1:0] v, input logic [NU*TW-1:0] tags, input int rct);
    int eu [PW];
    int ecnt;
    int taken;
    bit served [NU];
    logic [NU-1:0] erdy;
    logic [NU-1:0] acc;
    logic [TW-1:0] etag;
    fu_valid       = v;
    fu_tag         = tags;
    cmplt_ready_ct = CW'(rct);
    #1;
    ecnt = 0;
    for (int s = 0; s < PW; s++) eu[s] = 0;
    for (int k = 0; k < NU; k++) begin
      int u;
      u = (m_rr + k) % NU;
      if (mq[u].size() > 0 && ecnt < PW) begin
        eu[ecnt] = u;
        ecnt++;
      end
    end
    total++;
    if (cmplt_valid_ct !== CW'(ecnt)) begin
      bad++;
      $display("FAIL valid_ct: got %0d want %0d at %0t", cmplt_valid_ct, ecnt, $time);
    end
    for (int s = 0; s < PW; s++) begin
      etag = '0;
      if (s < ecnt) etag = mq[eu[s]][0];
      total++;
      if (completed[s*TW +: TW] !== etag) begin
        bad++;
        $display("FAIL slot%0d tag: got %0d want %0d at %0t", s, completed[s*TW +: TW], etag, $time);
      end
    end
    for (int u = 0; u < NU; u++) erdy[u] = m_warm && (mq[u].size() < 2);
    total++;
    if (fu_ready !== erdy) begin
      bad++;
      $display("FAIL fu_ready: got %b want %b at %0t", fu_ready, erdy, $time);
    end
    taken = imin(ecnt, imin(rct, PW));
    acc   = v & erdy;
    for (int u = 0; u < NU; u++) served[u] = 1'b0;
    for (int s = 0; s < taken; s++) begin
      n_deliv[eu[s]]++;
      served[eu[s]] = 1'b1;
      void'(mq[eu[s]].pop_front());
    end
    if (taken > 0) m_rr = (eu[taken-1] + 1) % NU;
    if (fair_on && taken > 0) begin
      for (int u = 0; u < NU; u++) begin
        if (served[u]) miss[u] = 0;
        else miss[u]++;
        if (miss[u] > max_miss) max_miss = miss[u];
      end
    end
    for (int u = 0; u < NU; u++)
      if (acc[u]) mq[u].push_back(tags[u*TW +: TW]);
    m_warm = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int u = 0; u < NU; u++) mq[u].delete();
    m_rr   = 0;
    m_warm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step('0, '0, 0);
  endtask

  task automatic test_reset();
    apply_reset();
    step(4'hF, {5'd14, 5'd13, 5'd12, 5'd11}, 0);
    step(4'hF, {5'd24, 5'd23, 5'd22, 5'd21}, 0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (cmplt_valid_ct !== 3'd0) begin
      bad++;
      $display("FAIL rst valid_ct: got %0d want 0", cmplt_valid_ct);
    end
    total++;
    if (fu_ready !== 4'h0) begin
      bad++;
      $display("FAIL rst fu_ready: got %b want 0000", fu_ready);
    end
    total++;
    if (completed !== '0) begin
      bad++;
      $display("FAIL rst completed: got %h want 0", completed);
    end
    for (int u = 0; u < NU; u++) mq[u].delete();
    m_rr   = 0;
    m_warm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step('0, '0, 0);
    total++;
    if (fu_ready !== 4'hF) begin
      bad++;
      $display("FAIL post-rst fu_ready: got %b want 1111", fu_ready);
    end
  endtask

  task automatic test_single_unit();
    step(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, 3);
    total++;
    if (completed[4:0] !== 5'd7 || cmplt_valid_ct !== 3'd1) begin
      bad++;
      $display("FAIL single N+1: got tag %0d ct %0d want tag 7 ct 1", completed[4:0], cmplt_valid_ct);
    end
    step('0, '0, 3);
    total++;
    if (cmplt_valid_ct !== 3'd0) begin
      bad++;
      $display("FAIL single N+2: got ct %0d want 0", cmplt_valid_ct);
    end
  endtask

  task automatic test_all_units();
    apply_reset();
    step(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 3);
    total++;
    if (completed !== {5'd3, 5'd2, 5'd1} || cmplt_valid_ct !== 3'd3) begin
      bad++;
      $display("FAIL all-units first: got %h ct %0d want %h ct 3", completed, cmplt_valid_ct, {5'd3, 5'd2, 5'd1});
    end
    step('0, '0, 3);
    total++;
    if (completed[4:0] !== 5'd4 || cmplt_valid_ct !== 3'd1) begin
      bad++;
      $display("FAIL all-units second: got tag %0d ct %0d want tag 4 ct 1", completed[4:0], cmplt_valid_ct);
    end
    step('0, '0, 3);
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] st [4];
    int nxt;
    int base;
    bool_dummy: begin end
    st[0] = 5'd10; st[1] = 5'd11; st[2] = 5'd12; st[3] = 5'd13;
    nxt  = 0;
    base = n_deliv[0];
    for (int c = 0; c < 4; c++) begin
      bit will_acc;
      will_acc = m_warm && (mq[0].size() < 2) && (nxt < 4);
      step((nxt < 4) ? 4'b0001 : 4'b0000, {15'd0, st[nxt % 4]}, 0);
      if (will_acc) nxt++;
    end
    total++;
    if (fu_ready[0] !== 1'b0 || completed[4:0] !== 5'd10) begin
      bad++;
      $display("FAIL backpressure full: got ready0 %b tag %0d want ready0 0 tag 10", fu_ready[0], completed[4:0]);
    end
    for (int c = 0; c < 10; c++) begin
      bit will_acc;
      will_acc = m_warm && (mq[0].size() < 2) && (nxt < 4);
      step((nxt < 4) ? 4'b0001 : 4'b0000, {15'd0, st[nxt % 4]}, 3);
      if (will_acc) nxt++;
    end
    total++;
    if (n_deliv[0] - base != 4 || cmplt_valid_ct !== 3'd0) begin
      bad++;
      $display("FAIL backpressure drain: got %0d tags ct %0d want 4 tags ct 0", n_deliv[0] - base, cmplt_valid_ct);
    end
  endtask

  task automatic test_partial_accept();
    apply_reset();
    step(4'b0111, {5'd0, 5'd23, 5'd22, 5'd21}, 0);
    total++;
    if (cmplt_valid_ct !== 3'd3) begin
      bad++;
      $display("FAIL partial offer: got ct %0d want 3", cmplt_valid_ct);
    end
    step('0, '0, 1);
    total++;
    if (cmplt_valid_ct !== 3'd2 || completed[4:0] !== 5'd22 || completed[9:5] !== 5'd23) begin
      bad++;
      $display("FAIL partial reoffer: got ct %0d slots %0d,%0d want ct 2 slots 22,23",
               cmplt_valid_ct, completed[4:0], completed[9:5]);
    end
    step('0, '0, 3);
  endtask

  task automatic test_fairness_soak();
    logic [NU*TW-1:0] tags;
    for (int u = 0; u < NU; u++) miss[u] = 0;
    max_miss = 0;
    fair_on  = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tags = NU*TW'($urandom);
      step(4'hF, tags, $urandom_range(0, 7));
    end
    fair_on = 1'b0;
    for (int c = 0; c < 6; c++) step('0, '0, 3);
    total++;
    if (max_miss >= NU) begin
      bad++;
      $display("FAIL fairness: got %0d taking cycles unserved want < %0d", max_miss, NU);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_unit();
    test_all_units();
    test_backpressure();
    test_partial_accept();
    test_fairness_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
